pcihellocore_in_conditioner: RTL and testbench
==============================================

// Module: pcihellocore_in_conditioner
// PURPOSE
//   Input conditioner directly upstream of the 16-bit PIO input port on the
//   PCI hello core. Takes raw asynchronous board inputs (switches/buttons) and
//   passes each bit through a synchronizer and a debouncer. Drives the
//   resulting stable word into the PIO in_port, plus per-bit edge pulses.
// PARAMETERS
//   WIDTH         16       number of input bits
//   SYNC_STAGES   2        synchronizer flops per bit (>=2)
//   TICK_DIV      500      clk cycles per debounce sample tick (>=1)
//   STABLE_TICKS  4        consecutive differing tick samples needed to accept a change (>=1)
//   RESET_VALUE   16'h0000 value of sync chain and data_out after reset
// PORTS
//   clk          in   1      system clock
//   reset        in   1      asynchronous reset, active-high
//   raw_in       in   WIDTH  raw asynchronous inputs
//   data_out     out  WIDTH  debounced stable value; connects to the PIO in_port
//   rise_pulse   out  WIDTH  1-cycle pulse per bit on a data_out 0->1 transition
//   fall_pulse   out  WIDTH  1-cycle pulse per bit on a data_out 1->0 transition
//   changed      out  1      1-cycle pulse; OR of all rise_pulse/fall_pulse bits
//   sample_tick  out  1      debounce tick strobe, for debug
// BEHAVIOUR
//   Reset (async assert; sampled deassert on clk)
//   - Sync flops and data_out = RESET_VALUE.
//   - Prescaler, per-bit counters, rise_pulse, fall_pulse, changed, sample_tick = 0.
//   Synchronizer
//   - raw_in passes through SYNC_STAGES flops; the last stage is sync[i].
//   Prescaler
//   - Counts 0..TICK_DIV-1, then wraps to 0.
//   - sample_tick = 1 for the single cycle in which count == TICK_DIV-1.
//   - TICK_DIV = 1: tick is high every cycle.
//   Per-bit debounce counter cnt[i], width $clog2(STABLE_TICKS+1)
//   - No tick: cnt[i] holds.
//   - Tick, sync[i] == data_out[i]: cnt[i] <= 0 (a glitch discards progress).
//   - Tick, sync[i] != data_out[i], cnt[i]+1 < STABLE_TICKS: cnt[i] <= cnt[i]+1.
//   - Tick, sync[i] != data_out[i], cnt[i]+1 == STABLE_TICKS:
//     data_out[i] <= sync[i] and cnt[i] <= 0.
//   - A change is therefore accepted on the STABLE_TICKS-th consecutive tick
//     on which sync[i] differs from data_out[i].
//   Edge outputs
//   - rise_pulse, fall_pulse and changed are registered. They are high in the
//     same cycle as the data_out update they describe, for exactly 1 cycle.
//   - Multiple bits updating on one tick update together; their pulses are
//     asserted in the same cycle.
//   Latency
//   - data_out is a registered output; no combinational path from raw_in.
//   - From a raw_in step to data_out: SYNC_STAGES cycles plus time to the
//     STABLE_TICKS-th qualifying tick. Maximum is SYNC_STAGES+STABLE_TICKS*TICK_DIV.
//   Boundaries
//   - Prescaler wrap occurs with no extra cycle.
//   - STABLE_TICKS = 1: a bit is accepted on the first differing tick.
//   - Reset mid-count: all partial counts are lost, and data_out returns to
//     RESET_VALUE immediately.
//   - After reset release, the prescaler restarts at 0.
// TESTING  (bench uses TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2 unless noted)
//   1. Hold reset with raw_in=16'hFFFF -> data_out=16'h0000; pulses, changed and
//      sample_tick stay 0.
//   2. Release reset, step raw_in 16'h0000->16'h0001 and hold -> data_out=16'h0001
//      on the 3rd tick after sync; rise_pulse=16'h0001 and changed=1 for 1 cycle.
//   3. From idle 16'h0000: raw_in bit5 high across 2 ticks, then low ->
//      data_out stays 16'h0000; no pulses.
//   4. With data_out stable at 16'h00F0, set raw_in=16'h0F00 -> data_out goes to
//      16'h0F00 in one cycle, with rise_pulse=16'h0F00, fall_pulse=16'h00F0, changed=1.
//   5. Pending change with 2 ticks counted, then pulse reset -> data_out=16'h0000;
//      after release, the change needs a full 3 new ticks.
//   6. TICK_DIV=1, STABLE_TICKS=1: a raw_in step appears on data_out exactly
//      3 cycles later; toggling every cycle gives a matching pulse each cycle.

Source files
------------

// File: rtl/pcihellocore_in_conditioner.sv
// Input conditioner for the PCI hello core PIO in_port: per-bit synchronizer, tick-sampled
// debouncer, and registered rise/fall/changed pulses aligned with the data_out update.
module pcihellocore_in_conditioner #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      TICK_DIV     = 500,
  parameter int unsigned      STABLE_TICKS = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed,
  output logic             sample_tick
);

  localparam int unsigned     PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned     CntW    = $clog2(STABLE_TICKS + 1);
  localparam logic [PreW-1:0] PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_bits;

  logic [PreW-1:0]  presc_q, presc_d;
  logic             tick_q, tick_d;

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  assign sync_bits = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // tick_q is registered from the next count so it is high exactly while presc_q == PreMax.
  always_comb begin
    presc_d = (presc_q == PreMax) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == PreMax);
  end

  always_comb begin
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q) begin
        if (sync_bits[i] == data_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          cnt_d[i]  = '0;
          data_d[i] = sync_bits[i];
          rise_d[i] = sync_bits[i];
          fall_d[i] = ~sync_bits[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      data_q    <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_out    = data_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign changed     = changed_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_pcihellocore_in_conditioner.sv
// Bench for pcihellocore_in_conditioner: directed scenarios plus random hold patterns checked
// against a cycle-count based reference model; a second instance covers TICK_DIV=1/STABLE_TICKS=1.
module tb_pcihellocore_in_conditioner;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] raw_in = '0;
  logic [15:0] raw2 = '0;
  logic [15:0] data_out, rise_pulse, fall_pulse;
  logic        changed, sample_tick;
  logic [15:0] data_out2, rise_pulse2, fall_pulse2;
  logic        changed2, sample_tick2;

  int errors = 0;
  int checks = 0;

  pcihellocore_in_conditioner #(
    .WIDTH(16), .SYNC_STAGES(SS), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VALUE(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .data_out(data_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .changed(changed),
    .sample_tick(sample_tick)
  );

  pcihellocore_in_conditioner #(
    .WIDTH(16), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VALUE(16'h0000)
  ) dut_fast (
    .clk(clk), .reset(reset), .raw_in(raw2), .data_out(data_out2),
    .rise_pulse(rise_pulse2), .fall_pulse(fall_pulse2), .changed(changed2),
    .sample_tick(sample_tick2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference model: cycles since reset decide tick cycles; raw is seen SS edges late;
  // a bit flips after ST consecutive differing ticks.
  int          m_cyc;
  logic [15:0] m_sync [SS];
  logic [15:0] m_data, m_rise, m_fall;
  logic        m_chg;
  int          m_run [16];

  function automatic void model_reset();
    m_cyc = 0;
    for (int s = 0; s < SS; s++) m_sync[s] = '0;
    m_data = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
  endfunction

  function automatic void model_edge(input logic [15:0] r);
    logic [15:0] seen;
    m_rise = '0;
    m_fall = '0;
    if (reset) begin
      model_reset();
      return;
    end
    seen = m_sync[SS-1];
    if (m_cyc % TD == TD - 1) begin
      for (int i = 0; i < 16; i++) begin
        if (seen[i] != m_data[i]) begin
          m_run[i]++;
          if (m_run[i] == ST) begin
            m_data[i] = seen[i];
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = r;
    m_chg = (m_rise != 0) || (m_fall != 0);
    m_cyc++;
  endfunction

  function automatic logic exp_tick();
    return !reset && (m_cyc % TD == TD - 1);
  endfunction

  // Drive raw_in, take one clock edge, advance the model, settle before sampling.
  task automatic cyc(input logic [15:0] r);
    raw_in = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(16'hFFFF);
      checks++;
      if (data_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_data k=%0d got %h expected 0000", k, data_out);
      end
      checks++;
      if ({rise_pulse, fall_pulse, changed, sample_tick} !== '0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got rise=%h fall=%h chg=%b tick=%b expected all 0",
                 k, rise_pulse, fall_pulse, changed, sample_tick);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_rise();
    int first_k;
    int n_rise;
    first_k = -1;
    n_rise  = 0;
    for (int k = 1; k <= 4; k++) cyc(16'h0000);
    for (int k = 1; k <= 20; k++) begin
      cyc(16'h0001);
      checks++;
      if (data_out !== m_data || rise_pulse !== m_rise || changed !== m_chg) begin
        errors++;
        $display("FAIL single_rise k=%0d got d=%h r=%h c=%b expected d=%h r=%h c=%b",
                 k, data_out, rise_pulse, changed, m_data, m_rise, m_chg);
      end
      if (rise_pulse == 16'h0001) n_rise++;
      if (first_k < 0 && data_out == 16'h0001) first_k = k;
    end
    checks++;
    if (first_k != 12) begin
      errors++;
      $display("FAIL single_rise_latency got %0d edges expected 12", first_k);
    end
    checks++;
    if (n_rise != 1) begin
      errors++;
      $display("FAIL single_rise_pulse_count got %0d expected 1", n_rise);
    end
  endtask

  task automatic test_glitch();
    int n_chg;
    n_chg = 0;
    for (int k = 0; k < 20; k++) cyc(16'h0000);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL glitch_idle got %h expected 0000", data_out);
    end
    for (int k = 0; k < 28; k++) begin
      cyc((k < 8) ? 16'h0020 : 16'h0000);
      if (changed) n_chg++;
      checks++;
      if (data_out !== m_data || data_out !== 16'h0000) begin
        errors++;
        $display("FAIL glitch_data k=%0d got %h expected 0000 (model %h)", k, data_out, m_data);
      end
    end
    checks++;
    if (n_chg != 0) begin
      errors++;
      $display("FAIL glitch_pulses got %0d changed pulses expected 0", n_chg);
    end
  endtask

  task automatic test_multi_bit();
    int          n_chg;
    logic [15:0] r_seen, f_seen;
    n_chg  = 0;
    r_seen = '0;
    f_seen = '0;
    for (int k = 0; k < 20; k++) cyc(16'h00F0);
    checks++;
    if (data_out !== 16'h00F0) begin
      errors++;
      $display("FAIL multi_setup got %h expected 00f0", data_out);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(16'h0F00);
      checks++;
      if (data_out !== m_data) begin
        errors++;
        $display("FAIL multi_data k=%0d got %h expected %h", k, data_out, m_data);
      end
      if (changed) begin
        n_chg++;
        r_seen = rise_pulse;
        f_seen = fall_pulse;
      end
    end
    checks++;
    if (n_chg != 1 || r_seen !== 16'h0F00 || f_seen !== 16'h00F0) begin
      errors++;
      $display("FAIL multi_pulses got n=%0d rise=%h fall=%h expected n=1 rise=0f00 fall=00f0",
               n_chg, r_seen, f_seen);
    end
    checks++;
    if (data_out !== 16'h0F00) begin
      errors++;
      $display("FAIL multi_final got %h expected 0f00", data_out);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int first_k;
    guard   = 0;
    first_k = -1;
    do begin
      cyc(16'h0003);
      guard++;
    end while (m_run[0] != 2 && guard < 30);
    checks++;
    if (m_run[0] != 2 || data_out !== 16'h0F00) begin
      errors++;
      $display("FAIL reset_mid_setup got run=%0d data=%h expected run=2 data=0f00",
               m_run[0], data_out);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_async got %h expected 0000", data_out);
    end
    cyc(16'h0003);
    cyc(16'h0003);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc(16'h0003);
      checks++;
      if (data_out !== m_data) begin
        errors++;
        $display("FAIL reset_mid_data k=%0d got %h expected %h", k, data_out, m_data);
      end
      if (first_k < 0 && data_out == 16'h0003) first_k = k;
    end
    checks++;
    if (first_k != 12) begin
      errors++;
      $display("FAIL reset_mid_latency got %0d edges expected 12", first_k);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int          hold;
    v = '0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) v = 16'($urandom);
      else                           v = v ^ (16'h0001 << $urandom_range(0, 15));
      hold = $urandom_range(1, 20);
      for (int k = 0; k < hold; k++) begin
        cyc(v);
        checks++;
        if (data_out !== m_data || rise_pulse !== m_rise || fall_pulse !== m_fall ||
            changed !== m_chg || sample_tick !== exp_tick()) begin
          errors++;
          $display("FAIL random n=%0d got d=%h r=%h f=%h c=%b t=%b expected d=%h r=%h f=%h c=%b t=%b",
                   n, data_out, rise_pulse, fall_pulse, changed, sample_tick,
                   m_data, m_rise, m_fall, m_chg, exp_tick());
        end
      end
    end
  endtask

  task automatic test_fast_path();
    logic [15:0] h2 [$];
    logic [15:0] v, e, p;
    int          first_j;
    first_j = -1;
    for (int j = 0; j < 20; j++) begin
      if (j < 4)      v = 16'h0000;
      else if (j < 8) v = 16'h0001;
      else            v = (j % 2 == 1) ? 16'hA5A5 : 16'h5A5A;
      raw2 = v;
      h2.push_back(v);
      cyc(16'h0000);
      e = (h2.size() >= 3) ? h2[h2.size()-3] : 16'h0000;
      p = (h2.size() >= 4) ? h2[h2.size()-4] : 16'h0000;
      checks++;
      if (data_out2 !== e || rise_pulse2 !== (e & ~p) || fall_pulse2 !== (~e & p) ||
          changed2 !== (e != p) || sample_tick2 !== 1'b1) begin
        errors++;
        $display("FAIL fast j=%0d got d=%h r=%h f=%h c=%b t=%b expected d=%h r=%h f=%h c=%b t=1",
                 j, data_out2, rise_pulse2, fall_pulse2, changed2, sample_tick2,
                 e, e & ~p, ~e & p, e != p);
      end
      if (first_j < 0 && data_out2 == 16'h0001) first_j = j;
    end
    checks++;
    if (first_j != 6) begin
      errors++;
      $display("FAIL fast_latency got edge %0d expected 6", first_j);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_rise();
    test_glitch();
    test_multi_bit();
    test_reset_mid();
    test_random();
    test_fast_path();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
